load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory stage sitting directly downstream of the execute-stage ALU.
- Consumes the ALU result: it is the effective address for loads and stores, or the passthrough writeback value for everything else.
- Drives a single-outstanding request/grant/rvalid data-memory port, then byte-aligns and extends load data before handing it to writeback.
- Stalls execute via in_ready while a memory access is in flight.

Parameters:
- AW, 32, data-memory address width.
- XLEN, 32, datapath width; fixed at 32.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  execute stage presents an instruction
- in_ready  output  1  unit can accept this cycle
- in_alu_result  input  32  ALU result: address for memory ops, writeback value otherwise
- in_store_data  input  32  rs2 value for stores
- in_funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- in_is_load  input  1  load instruction
- in_is_store  input  1  store instruction
- in_rd  input  5  destination register
- dmem_req  output  1  memory request valid
- dmem_gnt  input  1  request accepted this cycle
- dmem_we  output  1  1 = write
- dmem_addr  output  AW  word-aligned address (bits [1:0] = 0)
- dmem_be  output  4  byte enables
- dmem_wdata  output  32  lane-replicated store data
- dmem_rvalid  input  1  read data valid
- dmem_rdata  input  32  read word
- wb_valid  output  1  one-cycle writeback pulse
- wb_rd  output  5  destination register (0 for stores)
- wb_data  output  32  writeback value
- wb_trap  output  1  misaligned-access trap (macro only; else tied 0)

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0; wb_valid=0, wb_rd=0, wb_data=0, wb_trap=0.
- in_ready=1 only in IDLE. An instruction is accepted when in_valid & in_ready; all inputs are registered on acceptance.
- States: IDLE, REQ, WAIT_R.
- Non-memory instruction accepted in IDLE: the next cycle gives wb_valid=1, wb_data=in_alu_result, wb_rd=in_rd. State stays IDLE, so throughput is 1 per cycle.
- Load or store accepted in IDLE: go to REQ.
- REQ:
  - dmem_req=1; addr, we, be and wdata are held stable until dmem_gnt.
  - Store + gnt: next cycle wb_valid=1, wb_rd=0; go to IDLE.
  - Load + gnt: go to WAIT_R.
- WAIT_R: dmem_req=0. On dmem_rvalid, the next cycle gives wb_valid=1 with extracted data; go to IDLE.
- Minimum load latency, accept to wb_valid: 3 cycles (gnt in first REQ cycle, rvalid the following cycle).
- rvalid arriving in the same cycle as gnt is not supported; the memory must return rvalid at least 1 cycle after gnt.
- Byte lane: off = addr[1:0].
  - B: be = 0001 << off; wdata = {4{sd[7:0]}}.
  - H: be = 0011 << off; wdata = {2{sd[15:0]}}.
  - W: be = 1111; wdata = sd.
- Load extract:
  - B/BU takes rdata[8*off +: 8]; H/HU takes rdata[16*off[1] +: 16].
  - B and H sign-extend; BU and HU zero-extend.
- Unlisted funct3 codes are treated as W.
- in_is_load and in_is_store both set: treated as load.
- wb_valid is a single-cycle pulse; writeback always accepts it.
- Reset asserted mid-access: the transaction is abandoned, no wb pulse occurs, and any later rvalid is ignored.
- dmem_gnt or dmem_rvalid arriving in IDLE is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned means H with addr[0]=1, or W with addr[1:0]!=0.
  - A misaligned access issues no dmem_req and goes IDLE -> IDLE.
  - The next cycle gives wb_valid=1, wb_trap=1, wb_rd=0, wb_data=faulting address.
- Not defined:
  - No check is made; wb_trap is tied 0.
  - The address is forced to natural alignment: H clears addr[0]; W clears addr[1:0].

Test Plan:
- Non-memory op with alu_result=0x0000_1234, rd=5 -> wb_valid next cycle, wb_data=0x1234, wb_rd=5, in_ready stays 1.
- SB at addr 0x103, sd=0xAABBCCDD, gnt after 2 wait cycles -> dmem_addr=0x100, be=1000, wdata=0xDDDDDDDD held 3 cycles, then wb_valid with wb_rd=0.
- LB at 0x202, rdata=0x1280_FF00 -> wb_data=0xFFFF_FF80. LBU at the same address -> 0x0000_0080.
- LH at 0x302, rdata=0x8001_0000 -> wb_data=0xFFFF_8001. LW at 0x300 -> 0x8001_0000. in_ready=0 from accept until the wb pulse.
- rst_n pulled low in WAIT_R, then rvalid after release -> no wb_valid; outputs at reset values; next op accepted normally.
- With LSU_MISALIGN_TRAP_EN, LW at 0x401 -> no dmem_req, wb_trap=1, wb_data=0x401. Without the macro -> dmem_addr=0x400, normal load.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Data-memory port of the load/store unit: single-outstanding request/grant
// with a separate read-data-valid return. The LSU drives the master side.
interface load_store_unit_if #(
    parameter int AW = 32
);
    logic          dmem_req;
    logic          dmem_gnt;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [3:0]    dmem_be;
    logic [31:0]   dmem_wdata;
    logic          dmem_rvalid;
    logic [31:0]   dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory stage: issues loads/stores on the data-memory port, aligns and extends
// load data, and passes non-memory results straight to writeback.
// Optional: define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of aligning them.
module load_store_unit #(
    parameter int AW   = 32,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_store_data,
    input  logic [2:0]      in_funct3,
    input  logic            in_is_load,
    input  logic            in_is_store,
    input  logic [4:0]      in_rd,
    load_store_unit_if.master dmem,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_trap
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

    state_t          state_q, state_d;
    logic            accept, is_mem, is_byte, is_half, misalign;
    logic [1:0]      off_raw, off;
    logic [3:0]      be_next;
    logic [31:0]     wdata_next;
    logic [1:0]      ld_off_q;
    logic            ld_byte_q, ld_half_q, ld_signed_q;
    logic [4:0]      rd_q;
    logic [7:0]      rbyte;
    logic [15:0]     rhalf;
    logic [31:0]     load_ext;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid & in_ready;
    assign is_mem   = in_is_load | in_is_store;
    assign is_byte  = (in_funct3 == 3'b000) | (in_funct3 == 3'b100);
    assign is_half  = (in_funct3 == 3'b001) | (in_funct3 == 3'b101);
    assign off_raw  = in_alu_result[1:0];

    // Halfword and word accesses use their natural lane regardless of the low address bits.
    assign off = is_byte ? off_raw : (is_half ? {off_raw[1], 1'b0} : 2'b00);

    assign be_next    = is_byte ? (4'b0001 << off) : (is_half ? (4'b0011 << off) : 4'b1111);
    assign wdata_next = is_byte ? {4{in_store_data[7:0]}}
                      : (is_half ? {2{in_store_data[15:0]}} : in_store_data);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = (is_half & off_raw[0]) | (~is_byte & ~is_half & (off_raw != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign dmem.dmem_req = (state_q == REQ);

    assign rbyte    = dmem.dmem_rdata[{ld_off_q, 3'b000} +: 8];
    assign rhalf    = dmem.dmem_rdata[{ld_off_q[1], 4'b0000} +: 16];
    assign load_ext = ld_byte_q ? {{24{ld_signed_q & rbyte[7]}}, rbyte}
                    : (ld_half_q ? {{16{ld_signed_q & rhalf[15]}}, rhalf} : dmem.dmem_rdata);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && is_mem && !misalign) state_d = REQ;
            REQ:     if (dmem.dmem_gnt) state_d = dmem.dmem_we ? IDLE : WAIT_R;
            WAIT_R:  if (dmem.dmem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields are captured once at acceptance and held until the access completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_be    <= 4'b0000;
            dmem.dmem_wdata <= 32'h0;
            ld_off_q        <= 2'b00;
            ld_byte_q       <= 1'b0;
            ld_half_q       <= 1'b0;
            ld_signed_q     <= 1'b0;
            rd_q            <= 5'd0;
            wb_valid        <= 1'b0;
            wb_rd           <= 5'd0;
            wb_data         <= '0;
        end else begin
            wb_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept && !is_mem) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= in_rd;
                        wb_data  <= in_alu_result;
                    end else if (accept && misalign) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= 5'd0;
                        wb_data  <= in_alu_result;
                    end else if (accept) begin
                        dmem.dmem_we    <= in_is_store & ~in_is_load;
                        dmem.dmem_addr  <= {in_alu_result[AW-1:2], 2'b00};
                        dmem.dmem_be    <= be_next;
                        dmem.dmem_wdata <= wdata_next;
                        ld_off_q        <= off;
                        ld_byte_q       <= is_byte;
                        ld_half_q       <= is_half;
                        ld_signed_q     <= ~in_funct3[2];
                        rd_q            <= in_rd;
                    end
                end
                REQ: begin
                    if (dmem.dmem_gnt && dmem.dmem_we) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= 5'd0;
                        wb_data  <= '0;
                    end
                end
                WAIT_R: begin
                    if (dmem.dmem_rvalid) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_q;
                        wb_data  <= load_ext;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wb_trap <= 1'b0;
        else        wb_trap <= (state_q == IDLE) & accept & is_mem & misalign;
    end
`else
    assign wb_trap = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit: non-memory passthrough, stores with
// grant stalls, sign/zero-extended loads, reset mid-access, and misalignment.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_alu_result;
    logic [31:0] in_store_data;
    logic [2:0]  in_funct3;
    logic        in_is_load;
    logic        in_is_store;
    logic [4:0]  in_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_trap;

    int nAssert = 0;
    int nFail   = 0;

    load_store_unit_if #(.AW(32)) dmem ();

    load_store_unit #(.AW(32), .XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_alu_result (in_alu_result),
        .in_store_data (in_store_data),
        .in_funct3     (in_funct3),
        .in_is_load    (in_is_load),
        .in_is_store   (in_is_store),
        .in_rd         (in_rd),
        .dmem          (dmem.master),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .wb_trap       (wb_trap)
    );

    always #5 clk = ~clk;

    // Drive and sample 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAssert++;
        assert (observed === expected) else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Present one instruction for exactly one cycle; returns in the cycle after acceptance.
    task automatic applyStimulus(input logic [31:0] alu, input logic [31:0] sd, input logic [2:0] f3,
                                 input logic ld, input logic st, input logic [4:0] rd);
        in_valid      = 1'b1;
        in_alu_result = alu;
        in_store_data = sd;
        in_funct3     = f3;
        in_is_load    = ld;
        in_is_store   = st;
        in_rd         = rd;
        tick();
        in_valid    = 1'b0;
        in_is_load  = 1'b0;
        in_is_store = 1'b0;
    endtask

    // Load with grant in the first REQ cycle and rvalid the next cycle.
    task automatic doLoad(input string tag, input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] expAddr, input logic [31:0] rdata, input logic [31:0] expData);
        applyStimulus(addr, 32'h0, f3, 1'b1, 1'b0, rd);
        checkOutput({tag, " req"}, {31'b0, dmem.dmem_req}, 32'd1);
        checkOutput({tag, " we"}, {31'b0, dmem.dmem_we}, 32'd0);
        checkOutput({tag, " addr"}, dmem.dmem_addr, expAddr);
        checkOutput({tag, " ready in REQ"}, {31'b0, in_ready}, 32'd0);
        dmem.dmem_gnt = 1'b1;
        tick();
        dmem.dmem_gnt = 1'b0;
        checkOutput({tag, " req in WAIT_R"}, {31'b0, dmem.dmem_req}, 32'd0);
        checkOutput({tag, " ready in WAIT_R"}, {31'b0, in_ready}, 32'd0);
        checkOutput({tag, " no early wb"}, {31'b0, wb_valid}, 32'd0);
        dmem.dmem_rvalid = 1'b1;
        dmem.dmem_rdata  = rdata;
        tick();
        dmem.dmem_rvalid = 1'b0;
        checkOutput({tag, " wb_valid"}, {31'b0, wb_valid}, 32'd1);
        checkOutput({tag, " wb_data"}, wb_data, expData);
        checkOutput({tag, " wb_rd"}, {27'b0, wb_rd}, {27'b0, rd});
        checkOutput({tag, " wb_trap"}, {31'b0, wb_trap}, 32'd0);
        checkOutput({tag, " ready after"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n            = 1'b0;
        in_valid         = 1'b0;
        in_alu_result    = 32'h0;
        in_store_data    = 32'h0;
        in_funct3        = 3'b000;
        in_is_load       = 1'b0;
        in_is_store      = 1'b0;
        in_rd            = 5'd0;
        dmem.dmem_gnt    = 1'b0;
        dmem.dmem_rvalid = 1'b0;
        dmem.dmem_rdata  = 32'h0;
        #2;
        checkOutput("reset in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("reset dmem_req", {31'b0, dmem.dmem_req}, 32'd0);
        checkOutput("reset dmem_addr", dmem.dmem_addr, 32'h0);
        checkOutput("reset dmem_be", {28'b0, dmem.dmem_be}, 32'h0);
        checkOutput("reset wb_valid", {31'b0, wb_valid}, 32'd0);
        checkOutput("reset wb_data", wb_data, 32'h0);
        checkOutput("reset wb_trap", {31'b0, wb_trap}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Non-memory ops back to back: one writeback per cycle.
        in_valid = 1'b1; in_alu_result = 32'h0000_1234; in_rd = 5'd5; in_funct3 = 3'b010;
        tick();
        checkOutput("alu wb_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("alu wb_data", wb_data, 32'h0000_1234);
        checkOutput("alu wb_rd", {27'b0, wb_rd}, 32'd5);
        checkOutput("alu in_ready", {31'b0, in_ready}, 32'd1);
        in_alu_result = 32'h0000_0055; in_rd = 5'd6;
        tick();
        in_valid = 1'b0;
        checkOutput("alu2 wb_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("alu2 wb_data", wb_data, 32'h0000_0055);
        tick();
        checkOutput("alu pulse ends", {31'b0, wb_valid}, 32'd0);

        // Grant arriving while idle must be ignored.
        dmem.dmem_gnt = 1'b1;
        tick();
        dmem.dmem_gnt = 1'b0;
        checkOutput("idle gnt req", {31'b0, dmem.dmem_req}, 32'd0);
        checkOutput("idle gnt wb", {31'b0, wb_valid}, 32'd0);

        // SB at 0x103, grant after two wait cycles.
        applyStimulus(32'h0000_0103, 32'hAABB_CCDD, 3'b000, 1'b0, 1'b1, 5'd7);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("sb req c%0d", i), {31'b0, dmem.dmem_req}, 32'd1);
            checkOutput($sformatf("sb we c%0d", i), {31'b0, dmem.dmem_we}, 32'd1);
            checkOutput($sformatf("sb addr c%0d", i), dmem.dmem_addr, 32'h0000_0100);
            checkOutput($sformatf("sb be c%0d", i), {28'b0, dmem.dmem_be}, 32'h8);
            checkOutput($sformatf("sb wdata c%0d", i), dmem.dmem_wdata, 32'hDDDD_DDDD);
            checkOutput($sformatf("sb ready c%0d", i), {31'b0, in_ready}, 32'd0);
            if (i == 2) dmem.dmem_gnt = 1'b1;
            tick();
        end
        dmem.dmem_gnt = 1'b0;
        checkOutput("sb wb_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("sb wb_rd", {27'b0, wb_rd}, 32'd0);
        checkOutput("sb req done", {31'b0, dmem.dmem_req}, 32'd0);
        checkOutput("sb ready done", {31'b0, in_ready}, 32'd1);

        // SH at 0x102 with immediate grant.
        applyStimulus(32'h0000_0102, 32'h1234_ABCD, 3'b001, 1'b0, 1'b1, 5'd9);
        checkOutput("sh be", {28'b0, dmem.dmem_be}, 32'hC);
        checkOutput("sh wdata", dmem.dmem_wdata, 32'hABCD_ABCD);
        dmem.dmem_gnt = 1'b1;
        tick();
        dmem.dmem_gnt = 1'b0;
        checkOutput("sh wb_valid", {31'b0, wb_valid}, 32'd1);

        doLoad("lb",  32'h0000_0202, 3'b000, 5'd10, 32'h0000_0200, 32'h1280_FF00, 32'hFFFF_FF80);
        doLoad("lbu", 32'h0000_0202, 3'b100, 5'd11, 32'h0000_0200, 32'h1280_FF00, 32'h0000_0080);
        doLoad("lh",  32'h0000_0302, 3'b001, 5'd12, 32'h0000_0300, 32'h8001_0000, 32'hFFFF_8001);
        doLoad("lhu", 32'h0000_0302, 3'b101, 5'd13, 32'h0000_0300, 32'h8001_0000, 32'h0000_8001);
        doLoad("lw",  32'h0000_0300, 3'b010, 5'd14, 32'h0000_0300, 32'h8001_0000, 32'h8001_0000);

        // Reset while waiting for read data; the late rvalid must be ignored.
        applyStimulus(32'h0000_0300, 32'h0, 3'b010, 1'b1, 1'b0, 5'd15);
        dmem.dmem_gnt = 1'b1;
        tick();
        dmem.dmem_gnt = 1'b0;
        checkOutput("rst pre ready", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("rst in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst dmem_addr", dmem.dmem_addr, 32'h0);
        checkOutput("rst dmem_wdata", dmem.dmem_wdata, 32'h0);
        checkOutput("rst wb_data", wb_data, 32'h0);
        checkOutput("rst wb_rd", {27'b0, wb_rd}, 32'd0);
        tick();
        rst_n = 1'b1;
        dmem.dmem_rvalid = 1'b1;
        dmem.dmem_rdata  = 32'hDEAD_BEEF;
        tick();
        dmem.dmem_rvalid = 1'b0;
        checkOutput("rst late rvalid wb", {31'b0, wb_valid}, 32'd0);
        checkOutput("rst late rvalid data", wb_data, 32'h0);
        applyStimulus(32'h0000_0077, 32'h0, 3'b000, 1'b0, 1'b0, 5'd3);
        checkOutput("post rst wb_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("post rst wb_data", wb_data, 32'h0000_0077);

`ifdef LSU_MISALIGN_TRAP_EN
        applyStimulus(32'h0000_0401, 32'h0, 3'b010, 1'b1, 1'b0, 5'd16);
        checkOutput("mis req", {31'b0, dmem.dmem_req}, 32'd0);
        checkOutput("mis wb_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("mis wb_trap", {31'b0, wb_trap}, 32'd1);
        checkOutput("mis wb_data", wb_data, 32'h0000_0401);
        checkOutput("mis wb_rd", {27'b0, wb_rd}, 32'd0);
        checkOutput("mis ready", {31'b0, in_ready}, 32'd1);
        tick();
        checkOutput("mis trap pulse ends", {31'b0, wb_trap}, 32'd0);
`else
        doLoad("lw mis", 32'h0000_0401, 3'b010, 5'd16, 32'h0000_0400, 32'hCAFE_BABE, 32'hCAFE_BABE);
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
